// File: rtl/ble_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ble_pkg
// Purpose  : Shared BLE link-layer constants, FSM encoding and helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package ble_pkg;

    localparam logic [23:0] C_CRC_POLY_DEF = 24'h00065B;
    localparam logic [23:0] C_CRC_INIT_DEF = 24'h555555;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_AA   = 3'd2,
        ST_PDU  = 3'd3,
        ST_CRC  = 3'd4
    } tx_state_e;

    // The preamble alternates so that its last bit differs from the first AA bit.
    function automatic logic [7:0] preamble_byte(input logic aa_lsb);
        return aa_lsb ? 8'h55 : 8'hAA;
    endfunction

    function automatic logic [6:0] whiten_init(input logic [5:0] ch);
        logic [6:0] w;
        w[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            w[i+1] = ch[5-i];
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ble_crc_whiten.sv
`default_nettype none
// ============================================================================
// Module   : ble_crc_whiten
// Purpose  : Bit-serial CRC24 and 7-bit whitening LFSR with load and enables.
// Revision : 1.0 - initial release
// ============================================================================
module ble_crc_whiten
    import ble_pkg::*;
#(
    parameter logic [23:0] CRC_POLY = C_CRC_POLY_DEF,
    parameter logic [23:0] CRC_INIT = C_CRC_INIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [5:0] channel_i,
    input  logic       crc_en_i,
    input  logic       crc_shift_i,
    input  logic       data_i,
    input  logic       wh_en_i,
    output logic       crc_msb_o,
    output logic       wh_bit_o
);

    logic [23:0] crc_q, crc_d;
    logic [6:0]  w_q, w_d;
    logic        fb;

    always_comb begin
        crc_d = crc_q;
        w_d   = w_q;
        fb    = crc_q[23] ^ data_i;
        if (load_i) begin
            crc_d = CRC_INIT;
            w_d   = whiten_init(channel_i);
        end else begin
            if (crc_en_i) begin
                crc_d = {crc_q[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'h0);
            end else if (crc_shift_i) begin
                crc_d = {crc_q[22:0], 1'b0};
            end
            if (wh_en_i) begin
                w_d    = {w_q[5:0], w_q[6]};
                w_d[4] = w_q[3] ^ w_q[6];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc_q <= '0;
            w_q   <= '0;
        end else begin
            crc_q <= crc_d;
            w_q   <= w_d;
        end
    end

    assign crc_msb_o = crc_q[23];
    assign wh_bit_o  = w_q[6];

endmodule
`default_nettype wire

// File: rtl/ble_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : ble_packet_tx
// Purpose  : BLE 1M link-layer framer/serializer (preamble, AA, PDU, CRC24).
//            Optional whiten_bypass_i port under BLE_TX_WHITEN_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ble_packet_tx
    import ble_pkg::*;
#(
    parameter int unsigned CLK_PER_SYM = 16,
    parameter int unsigned PDU_LEN_MAX = 39,
    parameter logic [23:0] CRC_POLY    = C_CRC_POLY_DEF,
    parameter logic [23:0] CRC_INIT    = C_CRC_INIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [31:0] acc_addr_i,
    input  logic [5:0]  channel_i,
    input  logic [5:0]  pdu_len_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_valid_i,
`ifdef BLE_TX_WHITEN_BYPASS_EN
    input  logic        whiten_bypass_i,
`endif
    output logic        byte_ready_o,
    output logic        symbol_out_o,
    output logic        symbol_stb_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int DIV_W = (CLK_PER_SYM > 1) ? $clog2(CLK_PER_SYM) : 1;

    tx_state_e   state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [8:0]  bit_cnt_q, bit_cnt_d;
    logic [31:0] aa_q, aa_d;
    logic [5:0]  len_q, len_d;
    logic [5:0]  fetch_cnt_q, fetch_cnt_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_full_q, buf_full_d;
    logic [7:0]  shift_q, shift_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        byp_q, byp_d;

    logic        wrap, len_ok, byte_ready;
    logic        lfsr_load, crc_en, crc_shift, wh_en;
    logic        crc_msb, wh_bit, wbit;
    logic [8:0]  pdu_last;
    logic [7:0]  pre_byte;

    assign wrap       = (div_q == DIV_W'(CLK_PER_SYM - 1));
    assign len_ok     = (pdu_len_i >= 6'd2) && (pdu_len_i <= 6'(PDU_LEN_MAX));
    assign pdu_last   = {len_q, 3'b000} - 9'd1;
    assign pre_byte   = preamble_byte(aa_q[0]);
    assign byte_ready = (state_q != ST_IDLE) && !buf_full_q && (fetch_cnt_q < len_q);
    assign wbit       = wh_bit & ~byp_q;

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_cnt_d   = bit_cnt_q;
        aa_d        = aa_q;
        len_d       = len_q;
        fetch_cnt_d = fetch_cnt_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        shift_d     = shift_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        byp_d       = byp_q;
        lfsr_load   = 1'b0;
        crc_en      = 1'b0;
        crc_shift   = 1'b0;
        wh_en       = 1'b0;

        if (byte_valid_i && byte_ready) begin
            buf_d       = byte_data_i;
            buf_full_d  = 1'b1;
            fetch_cnt_d = fetch_cnt_q + 6'd1;
        end
        if (state_q != ST_IDLE) begin
            div_d = wrap ? '0 : div_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (start_i) begin
                    if (len_ok) begin
                        aa_d        = acc_addr_i;
                        len_d       = pdu_len_i;
`ifdef BLE_TX_WHITEN_BYPASS_EN
                        byp_d       = whiten_bypass_i;
`else
                        byp_d       = 1'b0;
`endif
                        lfsr_load   = 1'b1;
                        bit_cnt_d   = '0;
                        fetch_cnt_d = '0;
                        buf_full_d  = 1'b0;
                        state_d     = ST_PRE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PRE: begin
                if (wrap) begin
                    if (bit_cnt_q == 9'd7) begin
                        bit_cnt_d = '0;
                        state_d   = ST_AA;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 9'd1;
                    end
                end
            end
            ST_AA: begin
                if (wrap) begin
                    if (bit_cnt_q == 9'd31) begin
                        bit_cnt_d = '0;
                        if (buf_full_q) begin
                            shift_d    = buf_q;
                            buf_full_d = 1'b0;
                            state_d    = ST_PDU;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 9'd1;
                    end
                end
            end
            ST_PDU: begin
                if (wrap) begin
                    crc_en    = 1'b1;
                    wh_en     = 1'b1;
                    bit_cnt_d = bit_cnt_q + 9'd1;
                    if (bit_cnt_q == pdu_last) begin
                        bit_cnt_d = '0;
                        state_d   = ST_CRC;
                    end else if (bit_cnt_q[2:0] == 3'd7) begin
                        // Next byte must already be buffered when this one ends.
                        if (buf_full_q) begin
                            shift_d    = buf_q;
                            buf_full_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            ST_CRC: begin
                if (wrap) begin
                    crc_shift = 1'b1;
                    wh_en     = 1'b1;
                    if (bit_cnt_q == 9'd23) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 9'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_cnt_q   <= '0;
            aa_q        <= '0;
            len_q       <= '0;
            fetch_cnt_q <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            byp_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_cnt_q   <= bit_cnt_d;
            aa_q        <= aa_d;
            len_q       <= len_d;
            fetch_cnt_q <= fetch_cnt_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            shift_q     <= shift_d;
            done_q      <= done_d;
            err_q       <= err_d;
            byp_q       <= byp_d;
        end
    end

    ble_crc_whiten #(
        .CRC_POLY (CRC_POLY),
        .CRC_INIT (CRC_INIT)
    ) u_crc_whiten (
        .clk         (clk),
        .rst         (rst),
        .load_i      (lfsr_load),
        .channel_i   (channel_i),
        .crc_en_i    (crc_en),
        .crc_shift_i (crc_shift),
        .data_i      (shift_q[0]),
        .wh_en_i     (wh_en),
        .crc_msb_o   (crc_msb),
        .wh_bit_o    (wh_bit)
    );

    always_comb begin
        symbol_out_o = 1'b0;
        case (state_q)
            ST_PRE:  symbol_out_o = pre_byte[bit_cnt_q[2:0]];
            ST_AA:   symbol_out_o = aa_q[bit_cnt_q[4:0]];
            ST_PDU:  symbol_out_o = shift_q[0] ^ wbit;
            ST_CRC:  symbol_out_o = crc_msb ^ wbit;
            default: symbol_out_o = 1'b0;
        endcase
    end

    assign byte_ready_o = byte_ready;
    assign busy_o       = (state_q != ST_IDLE);
    assign symbol_stb_o = busy_o && (div_q == '0);
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ble_packet_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ble_packet_tx
// Purpose  : Scoreboard bench for ble_packet_tx: expected bit stream queued
//            at stimulus time, popped by a monitor on every symbol strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ble_packet_tx;

    localparam int CPS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] acc_addr_i = '0;
    logic [5:0]  channel_i = '0;
    logic [5:0]  pdu_len_i = '0;
    logic [7:0]  byte_data_i = '0;
    logic        byte_valid_i = 1'b0;
    logic        whiten_bypass = 1'b0;
    logic        byte_ready_o, symbol_out_o, symbol_stb_o, busy_o, done_o, err_o;

    always #5 clk = ~clk;

    ble_packet_tx #(.CLK_PER_SYM(CPS)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .acc_addr_i      (acc_addr_i),
        .channel_i       (channel_i),
        .pdu_len_i       (pdu_len_i),
        .byte_data_i     (byte_data_i),
        .byte_valid_i    (byte_valid_i),
`ifdef BLE_TX_WHITEN_BYPASS_EN
        .whiten_bypass_i (whiten_bypass),
`endif
        .byte_ready_o    (byte_ready_o),
        .symbol_out_o    (symbol_out_o),
        .symbol_stb_o    (symbol_stb_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o)
    );

    int   n_cmp = 0, n_fail = 0;
    bit   exp_q[$];
    int   busy_cyc = 0, stb_cnt = 0, done_cnt = 0, err_cnt = 0;
    int   cyc = 0, last_stb = 0;
    bit   e;
    logic [7:0] pdu_bytes [0:39];
    int   feed_n = 0, feed_idx = 0, feed_hold = -1;
    bit   feed_en = 1'b0;
    logic rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Monitor: pops the scoreboard on every strobe and watches pulses.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (busy_o) busy_cyc++;
            if (symbol_stb_o) begin
                if (stb_cnt > 0) check("stb_spacing", cyc - last_stb, CPS);
                last_stb = cyc;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_stb: strobe %0d with empty scoreboard", stb_cnt);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("bit%0d", stb_cnt), symbol_out_o, e);
                end
                stb_cnt++;
            end
            if (done_o) begin
                done_cnt++;
                check("done_busy", busy_o, 0);
                check("done_sym", symbol_out_o, 0);
            end
            if (err_o) begin
                err_cnt++;
                check("err_busy", busy_o, 0);
                check("err_sym", symbol_out_o, 0);
            end
        end
    end

    // Byte source: offers bytes in order, optionally withholding one index.
    initial begin
        forever begin
            @(negedge clk);
            rdy = byte_ready_o;
            if (feed_en && feed_idx < feed_n && feed_idx != feed_hold) begin
                byte_valid_i = 1'b1;
                byte_data_i  = pdu_bytes[feed_idx];
            end else begin
                byte_valid_i = 1'b0;
            end
            @(posedge clk);
            if (byte_valid_i && rdy && rst) feed_idx++;
        end
    end

    function automatic logic [6:0] wstep(input logic [6:0] w);
        logic [6:0] n;
        n    = {w[5:0], w[6]};
        n[4] = w[3] ^ w[6];
        return n;
    endfunction

    task automatic push_pkt(input logic [31:0] aa, input logic [5:0] ch, input int len,
                            input int nsent, input bit byp);
        logic [7:0]  pre;
        logic [23:0] crc;
        logic [6:0]  w;
        logic        b, fb, wb;
        pre = aa[0] ? 8'h55 : 8'hAA;
        for (int i = 0; i < 8; i++) exp_q.push_back(pre[i]);
        for (int i = 0; i < 32; i++) exp_q.push_back(aa[i]);
        crc  = 24'h555555;
        w[0] = 1'b1;
        for (int k = 0; k < 6; k++) w[k+1] = ch[5-k];
        for (int n = 0; n < nsent; n++) begin
            for (int i = 0; i < 8; i++) begin
                b  = pdu_bytes[n][i];
                wb = byp ? 1'b0 : w[6];
                exp_q.push_back(b ^ wb);
                fb  = crc[23] ^ b;
                crc = {crc[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h0);
                w   = wstep(w);
            end
        end
        if (nsent == len) begin
            for (int i = 0; i < 24; i++) begin
                wb = byp ? 1'b0 : w[6];
                exp_q.push_back(crc[23-i] ^ wb);
                w = wstep(w);
            end
        end
    endtask

    task automatic set_bytes(input logic [63:0] v);
        for (int i = 0; i < 8; i++) pdu_bytes[i] = v[8*i +: 8];
    endtask

    task automatic clear_counts();
        busy_cyc = 0; stb_cnt = 0; done_cnt = 0; err_cnt = 0;
    endtask

    task automatic run_pkt(input logic [31:0] aa, input logic [5:0] ch, input int len,
                           input int hold, input bit byp);
        clear_counts();
        exp_q.delete();
        feed_n = len; feed_idx = 0; feed_hold = hold; feed_en = 1'b1;
        if (len >= 2 && len <= 39) push_pkt(aa, ch, len, (hold < 0) ? len : hold, byp);
        @(negedge clk);
        acc_addr_i = aa; channel_i = ch; pdu_len_i = 6'(len);
        whiten_bypass = byp; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int t;
        t = 0;
        while (done_cnt + err_cnt == 0 && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: no done/err within %0d cycles", name, t);
        end
        repeat (4) @(negedge clk);
        feed_en = 1'b0;
    endtask

    task automatic check_pkt(input string name, input int len, input int dn, input int er, input int bits);
        check({name, "_busy_cycles"}, busy_cyc, bits * CPS);
        check({name, "_stb_count"}, stb_cnt, bits);
        check({name, "_done"}, done_cnt, dn);
        check({name, "_err"}, err_cnt, er);
        check({name, "_sb_left"}, exp_q.size(), 0);
        check({name, "_len"}, len, len);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_sym", symbol_out_o, 0);
        check("rst_stb", symbol_stb_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_ready", byte_ready_o, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Preamble / timing: adv AA, channel 37, 2-byte PDU.
        set_bytes(64'h0000_0000_0000_0042);
        run_pkt(32'h8E89BED6, 6'd37, 2, -1, 1'b0);
        wait_end("t_pre");
        check("t_pre_busy_cycles", busy_cyc, 1280);
        check("t_pre_stb_count", stb_cnt, 80);
        check("t_pre_done", done_cnt, 1);
        check("t_pre_err", err_cnt, 0);
        check("t_pre_sb_left", exp_q.size(), 0);

        // ADV_NONCONN_IND with a start attempt mid-packet that must be ignored.
        set_bytes(64'hF6E5_D4C3_B2A1_0602);
        run_pkt(32'h6B7D9171, 6'd37, 8, -1, 1'b0);
        repeat (700) @(negedge clk);
        acc_addr_i = 32'h0; channel_i = 6'd1; pdu_len_i = 6'd5; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_end("t_adv");
        check("t_adv_busy_cycles", busy_cyc, 2048);
        check("t_adv_stb_count", stb_cnt, 128);
        check("t_adv_done", done_cnt, 1);
        check("t_adv_err", err_cnt, 0);
        check("t_adv_sb_left", exp_q.size(), 0);

        // CRC packet: header 16'h0600 + 6 payload bytes.
        set_bytes(64'h0605_0403_0201_0600);
`ifdef BLE_TX_WHITEN_BYPASS_EN
        run_pkt(32'h8E89BED6, 6'd38, 8, -1, 1'b1);
`else
        run_pkt(32'h8E89BED6, 6'd38, 8, -1, 1'b0);
`endif
        wait_end("t_crc");
        check("t_crc_done", done_cnt, 1);
        check("t_crc_sb_left", exp_q.size(), 0);
        check("t_crc_stb_count", stb_cnt, 128);

        // Underrun: third byte never supplied.
        set_bytes(64'h8877_6655_4433_2211);
        run_pkt(32'h8E89BED6, 6'd39, 8, 2, 1'b0);
        wait_end("t_unr");
        check("t_unr_busy_cycles", busy_cyc, 56 * CPS);
        check("t_unr_stb_count", stb_cnt, 56);
        check("t_unr_err", err_cnt, 1);
        check("t_unr_done", done_cnt, 0);
        check("t_unr_sb_left", exp_q.size(), 0);

        // Bad lengths.
        run_pkt(32'h8E89BED6, 6'd37, 1, -1, 1'b0);
        wait_end("t_len1");
        check("t_len1_err", err_cnt, 1);
        check("t_len1_busy", busy_cyc, 0);
        check("t_len1_stb", stb_cnt, 0);
        run_pkt(32'h8E89BED6, 6'd37, 40, -1, 1'b0);
        wait_end("t_len40");
        check("t_len40_err", err_cnt, 1);
        check("t_len40_busy", busy_cyc, 0);
        check("t_len40_done", done_cnt, 0);

        // Reset at bit 50, then a normal packet.
        set_bytes(64'h0102_0304_0506_0708);
        run_pkt(32'h8E89BED6, 6'd39, 8, -1, 1'b0);
        begin
            int t;
            t = 0;
            while (stb_cnt < 50 && t < 3000) begin
                @(negedge clk);
                t++;
            end
            check("t_rst_reached_bit50", stb_cnt, 50);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        feed_en = 1'b0;
        #1;
        check("t_rst_sym", symbol_out_o, 0);
        check("t_rst_stb", symbol_stb_o, 0);
        check("t_rst_busy", busy_o, 0);
        check("t_rst_ready", byte_ready_o, 0);
        check("t_rst_done", done_o, 0);
        check("t_rst_err", err_o, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("t_rst_no_done", done_cnt, 0);
        check("t_rst_no_err", err_cnt, 0);
        set_bytes(64'h0000_0000_005A_C301);
        run_pkt(32'h12345677, 6'd0, 3, -1, 1'b0);
        wait_end("t_post");
        check_pkt("t_post", 3, 1, 0, 88);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
